// File: rtl/iot_event_arbiter_if.sv
// iot_event_arbiter_if: device request/ack and monitor-side signals of iot_event_arbiter
interface iot_event_arbiter_if #(
  parameter int N_DEV = 4,
  parameter int CNT_W = 8
);
  logic [N_DEV-1:0] req;
  logic [N_DEV-1:0] req_on_off;
  logic [N_DEV-1:0] ack;
  logic             change;
  logic             on_off;
  logic [CNT_W-1:0] count;
  logic             dropped;
  logic             busy;
  modport master (
    output req, req_on_off,
    input  ack, change, on_off, count, dropped, busy
  );
  modport slave (
    input  req, req_on_off,
    output ack, change, on_off, count, dropped, busy
  );
endinterface

// File: rtl/iot_event_arbiter.sv
// iot_event_arbiter: round-robin arbiter forwarding device on/off events to a shared monitor counter; optional DUP_FILTER_EN drops repeated on/off events per device
module iot_event_arbiter #(
  parameter int N_DEV = 4,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  iot_event_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_DEV);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;
  logic [IW:0]   idx;
  logic          g_on;
  logic          dup;
  logic          accept;
  logic          grant;
  // first requesting device at or after rr_ptr, wrapping modulo N_DEV; lowest offset wins
  always_comb begin
    pick = rr_ptr;
    idx = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(i);
      idx = idx >= (IW+1)'(N_DEV) ? idx - (IW+1)'(N_DEV) : idx;
      if (bus.req[idx[IW-1:0]]) pick = idx[IW-1:0];
    end
  end
  assign grant = state == IDLE && |bus.req;
  assign g_on  = bus.req_on_off[pick];
`ifdef DUP_FILTER_EN
  logic [N_DEV-1:0] act;
  assign dup = g_on == act[pick];
  // remember which devices are currently on so that repeated events are refused
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) act <= '0;
    else if (grant && accept) act[pick] <= g_on;
  end
`else
  assign dup = 1'b0;
`endif
  assign accept = !dup && (g_on ? bus.count != CNT_MAX : bus.count != '0);
  // the grant decision is registered on entry to ISSUE so every output is a flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      bus.ack     <= '0;
      bus.change  <= 1'b0;
      bus.on_off  <= 1'b0;
      bus.count   <= '0;
      bus.dropped <= 1'b0;
      bus.busy    <= 1'b0;
    end else if (grant) begin
      state       <= ISSUE;
      rr_ptr      <= pick == IW'(N_DEV - 1) ? '0 : pick + 1'b1;
      bus.ack     <= N_DEV'(1) << pick;
      bus.change  <= accept;
      bus.on_off  <= g_on;
      bus.count   <= !accept ? bus.count : g_on ? bus.count + 1'b1 : bus.count - 1'b1;
      bus.dropped <= !accept;
      bus.busy    <= 1'b1;
    end else begin
      state       <= IDLE;
      bus.ack     <= '0;
      bus.change  <= 1'b0;
      bus.dropped <= 1'b0;
      bus.busy    <= 1'b0;
    end
  end
endmodule
